// File: rtl/register_file_32x32.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_32x32
//  Brief    : DEPTH x WIDTH CPU register file with one synchronous write port,
//             two combinational read ports and a serial valid/ready dump engine.
//             Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
//  Revision : 1.0 - initial release
// ============================================================================
module register_file_32x32 #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [0:WIDTH-1]  writeData,
    input  logic [ADDR_W-1:0] readAddrA,
    output logic [0:WIDTH-1]  readDataA,
    input  logic [ADDR_W-1:0] readAddrB,
    output logic [0:WIDTH-1]  readDataB,
    input  logic              dumpStart,
    output logic              dumpBusy,
    output logic              dumpValid,
    input  logic              dumpReady,
    output logic [ADDR_W-1:0] dumpAddr,
    output logic [0:WIDTH-1]  dumpData
);

    localparam logic [0:0]        c_stIdle   = 1'b0;
    localparam logic [0:0]        c_stSend   = 1'b1;
    localparam logic [ADDR_W-1:0] c_lastAddr = ADDR_W'(DEPTH - 1);

    logic [0:WIDTH-1]  r_regs [DEPTH];
    logic [0:0]        r_state;
    logic [0:0]        w_stateNext;
    logic [ADDR_W-1:0] r_dumpAddr;
    logic [ADDR_W-1:0] w_dumpAddrNext;
    logic [ADDR_W-1:0] w_dumpAddrInc;
    logic [0:WIDTH-1]  r_dumpData;
    logic [0:WIDTH-1]  w_dumpDataNext;
    logic [0:WIDTH-1]  w_readDataA;
    logic [0:WIDTH-1]  w_readDataB;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (writeEnable && (writeAddr != '0)) begin
            r_regs[writeAddr] <= writeData;
        end
    end

    always_comb begin
        w_readDataA = (readAddrA == '0) ? '0 : r_regs[readAddrA];
        w_readDataB = (readAddrB == '0) ? '0 : r_regs[readAddrB];
`ifdef REGFILE_BYPASS_EN
        if (writeEnable && (writeAddr != '0) && (readAddrA == writeAddr)) begin
            w_readDataA = writeData;
        end
        if (writeEnable && (writeAddr != '0) && (readAddrB == writeAddr)) begin
            w_readDataB = writeData;
        end
`else
        // Reads see the stored value; a same-cycle write lands at the edge.
`endif
    end

    assign readDataA = w_readDataA;
    assign readDataB = w_readDataB;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_stIdle;
            r_dumpAddr <= '0;
            r_dumpData <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_dumpAddr <= w_dumpAddrNext;
            r_dumpData <= w_dumpDataNext;
        end
    end

    assign w_dumpAddrInc = r_dumpAddr + ADDR_W'(1);

    // Each beat is snapshotted from the array when loaded, so later writes
    // only show up for indices not yet captured.
    always_comb begin
        w_stateNext    = r_state;
        w_dumpAddrNext = r_dumpAddr;
        w_dumpDataNext = r_dumpData;
        case (r_state)
            c_stIdle: begin
                if (dumpStart) begin
                    w_stateNext    = c_stSend;
                    w_dumpAddrNext = '0;
                    w_dumpDataNext = '0;
                end
            end
            c_stSend: begin
                if (dumpReady) begin
                    if (r_dumpAddr == c_lastAddr) begin
                        w_stateNext = c_stIdle;
                    end else begin
                        w_dumpAddrNext = w_dumpAddrInc;
                        w_dumpDataNext = r_regs[w_dumpAddrInc];
                    end
                end
            end
            default: begin
                w_stateNext = c_stIdle;
            end
        endcase
    end

    assign dumpBusy  = (r_state == c_stSend);
    assign dumpValid = (r_state == c_stSend);
    assign dumpAddr  = r_dumpAddr;
    assign dumpData  = r_dumpData;

endmodule
`default_nettype wire

// File: tb/tb_register_file_32x32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file_32x32
//  Brief    : Self-checking bench for register_file_32x32 (reads, writes,
//             optional bypass, dump sequencing, stalls and reset abort).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_32x32;

    logic        clk = 1'b0;
    logic        reset;
    logic        writeEnable;
    logic [4:0]  writeAddr;
    logic [0:31] writeData;
    logic [4:0]  readAddrA;
    logic [0:31] readDataA;
    logic [4:0]  readAddrB;
    logic [0:31] readDataB;
    logic        dumpStart;
    logic        dumpBusy;
    logic        dumpValid;
    logic        dumpReady;
    logic [4:0]  dumpAddr;
    logic [0:31] dumpData;

    typedef struct packed {
        logic [4:0]  addr;
        logic [0:31] data;
    } beat_t;

    int          errors = 0;
    int          checks = 0;
    logic [0:31] mdl [32];
    beat_t       q [$];

    register_file_32x32 #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .writeEnable(writeEnable),
        .writeAddr  (writeAddr),
        .writeData  (writeData),
        .readAddrA  (readAddrA),
        .readDataA  (readDataA),
        .readAddrB  (readAddrB),
        .readDataB  (readDataB),
        .dumpStart  (dumpStart),
        .dumpBusy   (dumpBusy),
        .dumpValid  (dumpValid),
        .dumpReady  (dumpReady),
        .dumpAddr   (dumpAddr),
        .dumpData   (dumpData)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [0:31] d);
        writeEnable = 1'b1;
        writeAddr   = a;
        writeData   = d;
        step();
        writeEnable = 1'b0;
        if (a != 5'd0) mdl[a] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        @(negedge clk);
        checks++;
        if ({dumpBusy, dumpValid, dumpAddr, dumpData} !== 39'd0) begin
            errors++;
            $display("FAIL reset_dump: got busy=%b valid=%b addr=%0d data=%h, expected all zero",
                     dumpBusy, dumpValid, dumpAddr, dumpData);
        end
        for (int i = 0; i < 32; i++) begin
            readAddrA = 5'(i);
            readAddrB = 5'(31 - i);
            @(negedge clk);
            checks++;
            if (readDataA !== 32'h0 || readDataB !== 32'h0) begin
                errors++;
                $display("FAIL reset_read[%0d]: got A=%h B=%h, expected 0", i, readDataA, readDataB);
            end
        end
    endtask

    task automatic test_write_read();
        step();
        do_write(5'd5, 32'hDEADBEEF);
        readAddrA = 5'd5;
        readAddrB = 5'd5;
        @(negedge clk);
        checks++;
        if (readDataA !== 32'hDEADBEEF || readDataB !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_r5: got A=%h B=%h, expected deadbeef", readDataA, readDataB);
        end
        step();
        writeEnable = 1'b1;
        writeAddr   = 5'd0;
        writeData   = 32'h1;
        readAddrA   = 5'd0;
        @(negedge clk);
        checks++;
        if (readDataA !== 32'h0) begin
            errors++;
            $display("FAIL r0_same_cycle: got %h, expected 0", readDataA);
        end
        step();
        writeEnable = 1'b0;
        @(negedge clk);
        checks++;
        if (readDataA !== 32'h0 || readDataB !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL r0_after_write: got A=%h B=%h, expected A=0 B=deadbeef", readDataA, readDataB);
        end
    endtask

    task automatic test_bypass();
        logic [0:31] expSame;
        step();
        writeEnable = 1'b1;
        writeAddr   = 5'd7;
        writeData   = 32'h12345678;
        readAddrA   = 5'd7;
        readAddrB   = 5'd5;
`ifdef REGFILE_BYPASS_EN
        expSame = 32'h12345678;
`else
        expSame = mdl[7];
`endif
        @(negedge clk);
        checks++;
        if (readDataA !== expSame || readDataB !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_same_cycle: got A=%h B=%h, expected A=%h B=deadbeef",
                     readDataA, readDataB, expSame);
        end
        step();
        writeEnable = 1'b0;
        mdl[7] = 32'h12345678;
        @(negedge clk);
        checks++;
        if (readDataA !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_next_cycle: got %h, expected 12345678", readDataA);
        end
    endtask

    task automatic test_dump_full();
        beat_t      e;
        logic [4:0] nxt;
        int         beats;
        int         cyc;
        step();
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i * 3));
        q.delete();
        dumpReady = 1'b1;
        dumpStart = 1'b1;
        q.push_back(beat_t'({5'd0, 32'd0}));
        step();
        dumpStart = 1'b0;
        beats = 0;
        cyc   = 0;
        while (beats < 32 && cyc < 200 && q.size() > 0) begin
            // A start pulse on the final handshake must not relaunch the dump.
            dumpStart = (q[0].addr == 5'd31);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if ({dumpBusy, dumpValid, dumpAddr, dumpData} !== {2'b11, e}) begin
                errors++;
                $display("FAIL dump_full_beat: got busy=%b valid=%b addr=%0d data=%h, expected addr=%0d data=%h",
                         dumpBusy, dumpValid, dumpAddr, dumpData, e.addr, e.data);
            end
            beats++;
            if (e.addr != 5'd31) begin
                nxt = e.addr + 5'd1;
                q.push_back(beat_t'({nxt, mdl[nxt]}));
            end
            step();
            cyc++;
        end
        dumpStart = 1'b0;
        checks++;
        if (beats != 32) begin
            errors++;
            $display("FAIL dump_full_count: got %0d beats, expected 32", beats);
        end
        @(negedge clk);
        checks++;
        if (dumpBusy !== 1'b0 || dumpValid !== 1'b0) begin
            errors++;
            $display("FAIL dump_full_end: got busy=%b valid=%b, expected 0 0", dumpBusy, dumpValid);
        end
        step();
        @(negedge clk);
        checks++;
        if (dumpBusy !== 1'b0) begin
            errors++;
            $display("FAIL dump_full_restart: got busy=%b, expected 0", dumpBusy);
        end
    endtask

    task automatic test_dump_stall();
        beat_t      e;
        logic [4:0] nxt;
        int         beats;
        int         cyc;
        int         stall;
        bit         wrote20;
        step();
        q.delete();
        dumpReady = 1'b1;
        dumpStart = 1'b1;
        q.push_back(beat_t'({5'd0, 32'd0}));
        step();
        beats   = 0;
        cyc     = 0;
        stall   = 0;
        wrote20 = 1'b0;
        while (beats < 32 && cyc < 200 && q.size() > 0) begin
            writeEnable = 1'b0;
            dumpStart   = 1'b0;
            dumpReady   = 1'b1;
            if (dumpAddr == 5'd9 && stall < 4) begin
                dumpReady = 1'b0;
                dumpStart = 1'b1;
                stall++;
                if (stall == 1) begin
                    writeEnable = 1'b1;
                    writeAddr   = 5'd9;
                    writeData   = 32'hAA;
                end
            end else if (dumpAddr == 5'd12 && !wrote20) begin
                writeEnable = 1'b1;
                writeAddr   = 5'd20;
                writeData   = 32'hBB;
                dumpStart   = 1'b1;
                wrote20     = 1'b1;
            end
            @(negedge clk);
            e = q[0];
            checks++;
            if ({dumpBusy, dumpValid, dumpAddr, dumpData} !== {2'b11, e}) begin
                errors++;
                $display("FAIL dump_stall_beat: got busy=%b valid=%b addr=%0d data=%h, expected addr=%0d data=%h",
                         dumpBusy, dumpValid, dumpAddr, dumpData, e.addr, e.data);
            end
            if (dumpReady) begin
                void'(q.pop_front());
                beats++;
                if (e.addr != 5'd31) begin
                    nxt = e.addr + 5'd1;
                    q.push_back(beat_t'({nxt, mdl[nxt]}));
                end
            end
            step();
            if (writeEnable && writeAddr != 5'd0) mdl[writeAddr] = writeData;
            cyc++;
        end
        writeEnable = 1'b0;
        dumpStart   = 1'b0;
        checks++;
        if (beats != 32 || stall != 4) begin
            errors++;
            $display("FAIL dump_stall_count: got beats=%0d stalls=%0d, expected 32 and 4", beats, stall);
        end
        readAddrA = 5'd9;
        readAddrB = 5'd20;
        @(negedge clk);
        checks++;
        if (dumpBusy !== 1'b0 || readDataA !== 32'hAA || readDataB !== 32'hBB) begin
            errors++;
            $display("FAIL dump_stall_after: got busy=%b r9=%h r20=%h, expected 0 aa bb",
                     dumpBusy, readDataA, readDataB);
        end
    endtask

    task automatic test_dump_reset();
        beat_t      e;
        logic [4:0] nxt;
        int         cyc;
        step();
        q.delete();
        dumpReady = 1'b1;
        dumpStart = 1'b1;
        q.push_back(beat_t'({5'd0, 32'd0}));
        step();
        dumpStart = 1'b0;
        cyc = 0;
        while (dumpAddr != 5'd12 && cyc < 100 && q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if ({dumpValid, dumpAddr, dumpData} !== {1'b1, e}) begin
                errors++;
                $display("FAIL dump_reset_beat: got valid=%b addr=%0d data=%h, expected addr=%0d data=%h",
                         dumpValid, dumpAddr, dumpData, e.addr, e.data);
            end
            nxt = e.addr + 5'd1;
            q.push_back(beat_t'({nxt, mdl[nxt]}));
            step();
            cyc++;
        end
        checks++;
        if (dumpAddr !== 5'd12) begin
            errors++;
            $display("FAIL dump_reset_reach: got addr=%0d, expected 12", dumpAddr);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        q.delete();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        @(negedge clk);
        checks++;
        if ({dumpBusy, dumpValid, dumpAddr, dumpData} !== 39'd0) begin
            errors++;
            $display("FAIL dump_reset_abort: got busy=%b valid=%b addr=%0d data=%h, expected all zero",
                     dumpBusy, dumpValid, dumpAddr, dumpData);
        end
        for (int i = 0; i < 32; i++) begin
            readAddrA = 5'(i);
            readAddrB = 5'(i);
            @(negedge clk);
            checks++;
            if (readDataA !== mdl[i] || readDataB !== mdl[i]) begin
                errors++;
                $display("FAIL dump_reset_regs[%0d]: got A=%h B=%h, expected 0", i, readDataA, readDataB);
            end
        end
        step();
        dumpStart = 1'b1;
        step();
        dumpStart = 1'b0;
        @(negedge clk);
        checks++;
        if ({dumpBusy, dumpValid, dumpAddr, dumpData} !== {2'b11, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL dump_restart_beat0: got busy=%b valid=%b addr=%0d data=%h, expected 1 1 0 0",
                     dumpBusy, dumpValid, dumpAddr, dumpData);
        end
        step();
        @(negedge clk);
        checks++;
        if ({dumpValid, dumpAddr, dumpData} !== {1'b1, 5'd1, 32'd0}) begin
            errors++;
            $display("FAIL dump_restart_beat1: got valid=%b addr=%0d data=%h, expected 1 1 0",
                     dumpValid, dumpAddr, dumpData);
        end
    endtask

    initial begin
        reset       = 1'b1;
        writeEnable = 1'b0;
        writeAddr   = '0;
        writeData   = '0;
        readAddrA   = '0;
        readAddrB   = '0;
        dumpStart   = 1'b0;
        dumpReady   = 1'b0;
        test_reset();
        test_write_read();
        test_bypass();
        test_dump_full();
        test_dump_stall();
        test_dump_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
